// File: rtl/q2a03_bus_dma_if.sv
// Q2A03 bus bundle: CPU-side request fields, external bus and status lines.
// The optional DMC channel signals exist only with Q2A03_DMC_DMA_EN.
interface q2a03_bus_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_rdwr;
  logic        cpu_step;
  logic        cpu_halt;
  logic        G_ready;
  logic [7:0]  G_rd_data;
  logic [15:0] G_addr;
  logic [7:0]  G_wr_data;
  logic        G_rdwr;
  logic        G_phy2;
  logic        cycle_odd;
  logic        dma_busy;
`ifdef Q2A03_DMC_DMA_EN
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic        dmc_ack;
  logic [7:0]  dmc_data;

  modport slave (
    input  cpu_addr, cpu_wr_data, cpu_rdwr, G_ready, G_rd_data, dmc_req, dmc_addr,
    output cpu_step, cpu_halt, G_addr, G_wr_data, G_rdwr, G_phy2, cycle_odd, dma_busy,
           dmc_ack, dmc_data
  );
  modport master (
    output cpu_addr, cpu_wr_data, cpu_rdwr, G_ready, G_rd_data, dmc_req, dmc_addr,
    input  cpu_step, cpu_halt, G_addr, G_wr_data, G_rdwr, G_phy2, cycle_odd, dma_busy,
           dmc_ack, dmc_data
  );
`else
  modport slave (
    input  cpu_addr, cpu_wr_data, cpu_rdwr, G_ready, G_rd_data,
    output cpu_step, cpu_halt, G_addr, G_wr_data, G_rdwr, G_phy2, cycle_odd, dma_busy
  );
  modport master (
    output cpu_addr, cpu_wr_data, cpu_rdwr, G_ready, G_rd_data,
    input  cpu_step, cpu_halt, G_addr, G_wr_data, G_rdwr, G_phy2, cycle_odd, dma_busy
  );
`endif
endinterface

// File: rtl/q2a03_bus_dma.sv
// Q2A03 CPU-cycle phase generator and bus arbiter with OAM sprite DMA.
// Divides G_clock into CPU cycles, drives G_phy2 and the cpu_step strobe,
// and steals bus cycles to copy a page to DEST_ADDR after a write to DMA_REG.
// Optional feature macro: Q2A03_DMC_DMA_EN adds a higher-priority single-byte
// DMC fetch channel (dmc_req/dmc_addr/dmc_ack/dmc_data).
module q2a03_bus_dma #(
  parameter int          DIV        = 12,
  parameter int          PHI2_START = 6,
  parameter logic [15:0] DMA_REG    = 16'h4014,
  parameter logic [15:0] DEST_ADDR  = 16'h2004,
  parameter int          DMA_LEN    = 256
) (
  input logic            G_clock,
  input logic            G_reset,
  q2a03_bus_dma_if.slave bus
);
  localparam int            TW       = $clog2(DIV);
  localparam logic [TW-1:0] T_LAST   = TW'(DIV - 1);
  localparam logic [TW-1:0] T_PHI    = TW'(PHI2_START);
  localparam logic [7:0]    IDX_LAST = 8'(DMA_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_ALIGN, S_RD, S_WR, S_DDUM, S_DRD
  } state_t;

  state_t        st;
  logic [TW-1:0] tick, tick_nx;
  logic          cyc_end, phy2_r, odd_r;
  logic [7:0]    page, idx, dbuf;
  logic          dma_trig, halt_c;
`ifdef Q2A03_DMC_DMA_EN
  logic          oam_act;   // an OAM transfer is in flight (vs. DMC-only halt)
`endif

  assign cyc_end  = (tick == T_LAST);
  assign tick_nx  = cyc_end ? '0 : tick + TW'(1);
  assign dma_trig = cyc_end & ~bus.cpu_rdwr & (bus.cpu_addr == DMA_REG);
  // In HALT the CPU keeps running its write cycles; the first read freezes it.
  assign halt_c   = (st != S_IDLE) & ~((st == S_HALT) & ~bus.cpu_rdwr);

  assign bus.cpu_halt  = halt_c;
  // Reset holds tick at its last value, so the strobe is masked explicitly.
  assign bus.cpu_step  = cyc_end & ~halt_c & (bus.G_ready | ~bus.cpu_rdwr) & ~G_reset;
  assign bus.G_phy2    = phy2_r;
  assign bus.cycle_odd = odd_r;
  assign bus.dma_busy  = (st != S_IDLE);
`ifdef Q2A03_DMC_DMA_EN
  assign bus.dmc_ack   = (st == S_DRD) & cyc_end & bus.G_ready;
  assign bus.dmc_data  = bus.G_rd_data;
`endif

  // Phase generator: tick counter, registered phase-2 clock, cycle parity
  always_ff @(posedge G_clock or posedge G_reset) begin
    if (G_reset) begin
      tick   <= T_LAST;
      phy2_r <= 1'b1;
      odd_r  <= 1'b0;
    end else begin
      tick   <= tick_nx;
      phy2_r <= (tick_nx >= T_PHI);
      if (cyc_end) odd_r <= ~odd_r;
    end
  end

  // Bus mux: CPU owns the bus in IDLE/HALT, the DMA engine otherwise
  always_comb begin
    bus.G_addr    = bus.cpu_addr;
    bus.G_wr_data = bus.cpu_wr_data;
    bus.G_rdwr    = bus.cpu_rdwr;
    case (st)
      S_ALIGN: begin
        bus.G_rdwr    = 1'b1;
        bus.G_wr_data = dbuf;
      end
      S_RD: begin
        bus.G_addr    = {page, idx};
        bus.G_rdwr    = 1'b1;
        bus.G_wr_data = dbuf;
      end
      S_WR: begin
        bus.G_addr    = DEST_ADDR;
        bus.G_rdwr    = 1'b0;
        bus.G_wr_data = dbuf;
      end
`ifdef Q2A03_DMC_DMA_EN
      S_DDUM: begin
        bus.G_rdwr    = 1'b1;
        bus.G_wr_data = dbuf;
      end
      S_DRD: begin
        bus.G_addr    = bus.dmc_addr;
        bus.G_rdwr    = 1'b1;
        bus.G_wr_data = dbuf;
      end
`endif
      default: ;
    endcase
  end

  // DMA sequencer: every transition happens on a CPU cycle end
  always_ff @(posedge G_clock or posedge G_reset) begin
    if (G_reset) begin
      st   <= S_IDLE;
      page <= '0;
      idx  <= '0;
      dbuf <= '0;
`ifdef Q2A03_DMC_DMA_EN
      oam_act <= 1'b0;
`endif
    end else if (cyc_end) begin
      case (st)
        S_IDLE: begin
          // The triggering write itself still goes out on the bus.
          if (dma_trig) begin
            page <= bus.cpu_wr_data;
            st   <= S_HALT;
          end
`ifdef Q2A03_DMC_DMA_EN
          oam_act <= dma_trig;
          if (bus.dmc_req) st <= S_HALT;
`endif
        end
        S_HALT: if (bus.cpu_rdwr) begin
          // Reads must land on put cycles; a get-parity next cycle needs a dummy.
          st <= odd_r ? S_ALIGN : S_RD;
`ifdef Q2A03_DMC_DMA_EN
          if (bus.dmc_req)  st <= S_DDUM;
          else if (!oam_act) st <= S_IDLE;
`endif
        end
        S_ALIGN: begin
          st <= S_RD;
`ifdef Q2A03_DMC_DMA_EN
          if (bus.dmc_req) st <= S_DDUM;
`endif
        end
        S_RD: if (bus.G_ready) begin
          dbuf <= bus.G_rd_data;
          st   <= S_WR;
        end
        S_WR: begin
          if (idx == IDX_LAST) begin
            idx <= '0;
            st  <= S_IDLE;
`ifdef Q2A03_DMC_DMA_EN
            oam_act <= 1'b0;
`endif
          end else begin
            idx <= idx + 8'd1;
            st  <= S_RD;
          end
`ifdef Q2A03_DMC_DMA_EN
          if (bus.dmc_req) st <= S_DDUM;
`endif
        end
`ifdef Q2A03_DMC_DMA_EN
        S_DDUM: st <= S_DRD;
        S_DRD: if (bus.G_ready) begin
          if (bus.dmc_req)  st <= S_DDUM;
          else if (oam_act) st <= S_RD;
          else              st <= S_IDLE;
        end
`endif
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule
